// File: rtl/mmio_fifo_port_pkg.sv
// Shared definitions for the MMIO FIFO port: register offsets, STATUS and
// CTRL bit positions, and the STATUS word packing helper.
package mmio_fifo_port_pkg;

  // Word offsets inside the 16-byte register window (addr[3:2]).
  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_RXDATA = 2'd1,
    OFF_STATUS = 2'd2,
    OFF_CTRL   = 2'd3
  } reg_off_e;

  // STATUS bit positions.
  localparam int unsigned STAT_TX_EMPTY     = 0;
  localparam int unsigned STAT_TX_FULL      = 1;
  localparam int unsigned STAT_RX_EMPTY     = 2;
  localparam int unsigned STAT_RX_FULL      = 3;
  localparam int unsigned STAT_TX_OVF       = 4;
  localparam int unsigned STAT_RX_UNF       = 5;
  localparam int unsigned STAT_TX_COUNT_LSB = 8;
  localparam int unsigned STAT_RX_COUNT_LSB = 16;
  localparam int unsigned STAT_COUNT_W      = 5;

  // CTRL bit positions.
  localparam int unsigned CTRL_FLUSH_TX  = 0;
  localparam int unsigned CTRL_FLUSH_RX  = 1;
  localparam int unsigned CTRL_CLR_FLAGS = 2;

  // Assemble the STATUS word; every bit not named here reads as zero.
  function automatic logic [31:0] pack_status(
    input logic                    tx_empty,
    input logic                    tx_full,
    input logic                    rx_empty,
    input logic                    rx_full,
    input logic                    tx_ovf,
    input logic                    rx_unf,
    input logic [STAT_COUNT_W-1:0] tx_count,
    input logic [STAT_COUNT_W-1:0] rx_count
  );
    logic [31:0] s;
    s                                        = 32'd0;
    s[STAT_TX_EMPTY]                         = tx_empty;
    s[STAT_TX_FULL]                          = tx_full;
    s[STAT_RX_EMPTY]                         = rx_empty;
    s[STAT_RX_FULL]                          = rx_full;
    s[STAT_TX_OVF]                           = tx_ovf;
    s[STAT_RX_UNF]                           = rx_unf;
    s[STAT_TX_COUNT_LSB +: STAT_COUNT_W]     = tx_count;
    s[STAT_RX_COUNT_LSB +: STAT_COUNT_W]     = rx_count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_fifo_port_if.sv
// Processor-side memory-mapped bus: address/data/strobes out, load data back.
interface mmio_fifo_port_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata;

  modport master (
    output addr, wdata, mem_write, mem_read,
    input  rdata
  );

  modport slave (
    input  addr, wdata, mem_write, mem_read,
    output rdata
  );
endinterface

// File: rtl/mmio_fifo_port_sync_fifo.sv
// Single-clock FIFO with push/pop/flush. Full/empty are judged on the
// start-of-cycle state, so a push into a full FIFO is dropped even when a
// pop happens in the same cycle. The head reads as zero while empty so no
// stale storage word ever leaks out after reset or flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en_s;
  logic             pop_en_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign head_data = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Next pointers and occupancy; flush beats any same-cycle push or pop.
  always_comb begin
    push_en_s = push && !full;
    pop_en_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are never cleared, the empty gate hides them.
  always_ff @(posedge clk) begin
    if (push_en_s && !flush && !rst) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mmio_fifo_port.sv
// Memory-mapped TX/RX FIFO port: a 16-byte register window lets the
// processor push words toward an external consumer and pop words offered
// by an external producer, with STATUS/CTRL registers and sticky error flags.
module mmio_fifo_port
  import mmio_fifo_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mmio_fifo_port_if.slave         bus,
  output logic [31:0]             tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [31:0]             rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             hit_s;
  reg_off_e         off_s;
  logic             tx_push_req_s;
  logic             rx_pop_req_s;
  logic             ctrl_wr_s;
  logic             tx_flush_s;
  logic             rx_flush_s;
  logic             flag_clr_s;
  logic             tx_ovf_set_s;
  logic             rx_unf_set_s;
  logic             tx_pop_s;
  logic             rx_push_s;
  logic             tx_full_s, tx_empty_s;
  logic             rx_full_s, rx_empty_s;
  logic [CNT_W-1:0] tx_count_s, rx_count_s;
  logic [31:0]      tx_head_s, rx_head_s;
  logic [31:0]      status_s;
  logic             unused_addr_s;

  logic             tx_ovf_q, tx_ovf_d;
  logic             rx_unf_q, rx_unf_d;
  logic [31:0]      rdata_q, rdata_d;

  // Byte-lane bits do not take part in decode.
  assign unused_addr_s = ^bus.addr[1:0];

  assign hit_s         = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off_s         = reg_off_e'(bus.addr[3:2]);
  assign tx_push_req_s = bus.mem_write && hit_s && (off_s == OFF_TXDATA);
  assign rx_pop_req_s  = bus.mem_read  && hit_s && (off_s == OFF_RXDATA);
  assign ctrl_wr_s     = bus.mem_write && hit_s && (off_s == OFF_CTRL);
  assign tx_flush_s    = ctrl_wr_s && bus.wdata[CTRL_FLUSH_TX];
  assign rx_flush_s    = ctrl_wr_s && bus.wdata[CTRL_FLUSH_RX];
  assign flag_clr_s    = ctrl_wr_s && bus.wdata[CTRL_CLR_FLAGS];
  assign tx_ovf_set_s  = tx_push_req_s && tx_full_s;
  assign rx_unf_set_s  = rx_pop_req_s && rx_empty_s;

  assign tx_valid  = !tx_empty_s;
  assign tx_data   = tx_head_s;
  assign rx_ready  = !rx_full_s;
  assign tx_pop_s  = tx_valid && tx_ready;
  assign rx_push_s = rx_valid && rx_ready;
  assign bus.rdata = rdata_q;

  assign status_s = pack_status(tx_empty_s, tx_full_s, rx_empty_s, rx_full_s,
                                tx_ovf_q, rx_unf_q,
                                STAT_COUNT_W'(tx_count_s),
                                STAT_COUNT_W'(rx_count_s));

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push_req_s),
    .push_data (bus.wdata),
    .pop       (tx_pop_s),
    .flush     (tx_flush_s),
    .head_data (tx_head_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s),
    .count     (tx_count_s)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_s),
    .push_data (rx_data),
    .pop       (rx_pop_req_s),
    .flush     (rx_flush_s),
    .head_data (rx_head_s),
    .full      (rx_full_s),
    .empty     (rx_empty_s),
    .count     (rx_count_s)
  );

  // Load data: RXDATA head or STATUS on a hit load, zero on any other load,
  // otherwise hold the last value.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.mem_read) begin
      if (hit_s) begin
        case (off_s)
          OFF_RXDATA: rdata_d = rx_empty_s ? 32'd0 : rx_head_s;
          OFF_STATUS: rdata_d = status_s;
          default:    rdata_d = 32'd0;
        endcase
      end else begin
        rdata_d = 32'd0;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Sticky error flags: setting wins over a same-cycle clear.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (tx_ovf_set_s) begin
      tx_ovf_d = 1'b1;
    end else if (flag_clr_s) begin
      tx_ovf_d = 1'b0;
    end else begin
      tx_ovf_d = tx_ovf_q;
    end
    if (rx_unf_set_s) begin
      rx_unf_d = 1'b1;
    end else if (flag_clr_s) begin
      rx_unf_d = 1'b0;
    end else begin
      rx_unf_d = rx_unf_q;
    end
  end

  // Register load data and flags; reset overrides any same-cycle access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= 32'd0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

endmodule
